pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: stage write enables, bubble inserts and PC redirect.
// Optional stall-cycle counter is built only when PIPE_STALL_CNT_EN is defined.
module pipe_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IReq_Busy,
   input  logic             DReq_Busy,
   input  logic             Div_Busy,
   input  logic             ID_LoadUse,
   input  logic             EX_BranchFail,
   input  logic             MEM_Exception,
   input  logic             WB_IsTLBW,
   input  logic             WB_IsTLBR,
   output logic             PC_Wr,
   output logic             ID_Wr,
   output logic             EX_Wr,
   output logic             MEM_Wr,
   output logic             WB_Wr,
   output logic             ID_Flush,
   output logic             EX_Flush,
   output logic             MEM_Flush,
   output logic             WB_Flush,
   output logic [1:0]       Redirect_Sel,
   output logic [1:0]       Ctrl_State,
   output logic [CNT_W-1:0] Stall_Cnt
);

   localparam logic [1:0] ST_RUN     = 2'b00;
   localparam logic [1:0] ST_DRAIN   = 2'b01;
   localparam logic [1:0] ST_REFETCH = 2'b10;

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_EXC    = 2'b10;
   localparam logic [1:0] SEL_REFTCH = 2'b11;

   logic [1:0] state;
   logic [1:0] state_nxt;

   logic tlb_req;
   logic act_exc;
   logic act_tlb;
   logic act_dstall;
   logic act_hold_ex;
   logic act_br_go;
   logic act_loaduse;
   logic act_istall;
   logic act_refetch;

   assign tlb_req = WB_IsTLBW | WB_IsTLBR;

   // State register; reset abandons any pending drain or refetch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Winning action and next state; at most one act_* is set per cycle
   always_comb begin
      state_nxt   = ST_RUN;
      act_exc     = 1'b0;
      act_tlb     = 1'b0;
      act_dstall  = 1'b0;
      act_hold_ex = 1'b0;
      act_br_go   = 1'b0;
      act_loaduse = 1'b0;
      act_istall  = 1'b0;
      act_refetch = 1'b0;
      case (state)
         ST_RUN: begin
            if (MEM_Exception) begin
               if (DReq_Busy) begin
                  act_dstall = 1'b1;
                  state_nxt  = ST_DRAIN;
               end else begin
                  act_exc = 1'b1;
               end
            end else if (tlb_req) begin
               act_tlb   = 1'b1;
               state_nxt = ST_REFETCH;
            end else if (DReq_Busy) begin
               act_dstall = 1'b1;
            end else if (EX_BranchFail) begin
               // A failed branch waits in EX until the fetch it replaces returns
               if (IReq_Busy) begin
                  act_hold_ex = 1'b1;
               end else begin
                  act_br_go = 1'b1;
               end
            end else if (Div_Busy) begin
               act_hold_ex = 1'b1;
            end else if (ID_LoadUse) begin
               act_loaduse = 1'b1;
            end else if (IReq_Busy) begin
               act_istall = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (DReq_Busy) begin
               act_dstall = 1'b1;
               state_nxt  = ST_DRAIN;
            end else begin
               act_exc = 1'b1;
            end
         end
         ST_REFETCH: begin
            act_refetch = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Stage enables, bubbles and redirect from the selected action
   always_comb begin
      PC_Wr        = 1'b1;
      ID_Wr        = 1'b1;
      EX_Wr        = 1'b1;
      MEM_Wr       = 1'b1;
      WB_Wr        = 1'b1;
      ID_Flush     = 1'b0;
      EX_Flush     = 1'b0;
      MEM_Flush    = 1'b0;
      WB_Flush     = 1'b0;
      Redirect_Sel = SEL_SEQ;
      if (rst) begin
         PC_Wr     = 1'b0;
         ID_Wr     = 1'b0;
         EX_Wr     = 1'b0;
         MEM_Wr    = 1'b0;
         WB_Wr     = 1'b0;
         ID_Flush  = 1'b1;
         EX_Flush  = 1'b1;
         MEM_Flush = 1'b1;
         WB_Flush  = 1'b1;
      end else if (act_exc) begin
         ID_Flush     = 1'b1;
         EX_Flush     = 1'b1;
         MEM_Flush    = 1'b1;
         Redirect_Sel = SEL_EXC;
      end else if (act_tlb) begin
         ID_Flush     = 1'b1;
         EX_Flush     = 1'b1;
         MEM_Flush    = 1'b1;
         Redirect_Sel = SEL_REFTCH;
      end else if (act_dstall) begin
         PC_Wr    = 1'b0;
         ID_Wr    = 1'b0;
         EX_Wr    = 1'b0;
         MEM_Wr   = 1'b0;
         WB_Flush = 1'b1;
      end else if (act_hold_ex) begin
         PC_Wr     = 1'b0;
         ID_Wr     = 1'b0;
         EX_Wr     = 1'b0;
         MEM_Flush = 1'b1;
      end else if (act_br_go) begin
         ID_Flush     = 1'b1;
         Redirect_Sel = SEL_BRANCH;
      end else if (act_loaduse) begin
         PC_Wr    = 1'b0;
         ID_Wr    = 1'b0;
         EX_Flush = 1'b1;
      end else if (act_istall || act_refetch) begin
         PC_Wr    = 1'b0;
         ID_Flush = 1'b1;
      end
   end

   assign Ctrl_State = state;

`ifdef PIPE_STALL_CNT_EN
   // Free-running count of cycles with the PC held; wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Stall_Cnt <= '0;
      end else if (!PC_Wr) begin
         Stall_Cnt <= Stall_Cnt + CNT_W'(1);
      end
   end
`else
   assign Stall_Cnt = '0;
`endif

endmodule
